// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron array.
//   mem_t    : wide signed carrier for membrane arithmetic; users narrow it
//              to their own WIDTH (any WIDTH up to MAX_W is supported).
//   state_t  : sweep controller states.
//   sat_add  : signed add clamped to the range of a w-bit signed value.
package snn_pkg;

    localparam int MAX_W = 32;

    typedef logic signed [MAX_W-1:0] mem_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Operands are expected to already lie inside the w-bit signed range,
    // so one guard bit is enough to see any overflow before clamping.
    function automatic mem_t sat_add(input mem_t a, input mem_t b, input int w);
        logic signed [MAX_W:0] sum;
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        sum = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi[MAX_W-1:0];
        end else if (sum < lo) begin
            return lo[MAX_W-1:0];
        end else begin
            return sum[MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational update of a single leaky-integrate-and-fire neuron.
//   mem, cur    : current membrane and input current (signed, WIDTH)
//   refrac      : remaining refractory timesteps
//   leak_en     : apply leak in this update
//   next_mem    : membrane value to write back
//   next_refrac : refractory count to write back
//   fire        : neuron spikes in this update
module lif_core
    import snn_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int THRESH     = 32,
    parameter int RESET_VAL  = 0,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int RF_W       = 2
) (
    input  logic signed [WIDTH-1:0] mem,
    input  logic signed [WIDTH-1:0] cur,
    input  logic        [RF_W-1:0]  refrac,
    input  logic                    leak_en,
    output logic signed [WIDTH-1:0] next_mem,
    output logic        [RF_W-1:0]  next_refrac,
    output logic                    fire
);

    localparam logic signed [WIDTH-1:0] RST_MEM = WIDTH'(RESET_VAL);

    mem_t                    sum_w_s;
    logic signed [WIDTH-1:0] sum_s;

    // Refractory hold, threshold test and leak for one neuron.
    always_comb begin
        sum_w_s     = sat_add(mem_t'(mem), mem_t'(cur), WIDTH);
        sum_s       = sum_w_s[WIDTH-1:0];
        next_mem    = sum_s;
        next_refrac = refrac;
        fire        = 1'b0;
        if (refrac != '0) begin
            // Input current is discarded while refractory.
            next_refrac = refrac - RF_W'(1'b1);
            next_mem    = RST_MEM;
        end else if (sum_w_s >= mem_t'(THRESH)) begin
            fire        = 1'b1;
            next_mem    = RST_MEM;
            next_refrac = RF_W'(REFRAC);
        end else if (leak_en && (LEAK_SHIFT > 0)) begin
            // Arithmetic shift rounds toward -inf, so negative values decay
            // toward zero without crossing it.
            next_mem = sum_s - (sum_s >>> LEAK_SHIFT);
        end else begin
            next_mem = sum_s;
        end
    end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed LIF neuron array: one shared lif_core sweeps all neurons,
// one per cycle, after each start pulse and emits a dense spike stream.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, clear    : begin a timestep / zero all state (accepted when idle)
//   leak_en         : leak enable, latched at start
//   cur_idx, cur_in : current request index and same-cycle current
//   spk_valid, spk_idx, spk : registered spike-stream entry
//   busy, done      : timestep in progress / end-of-timestep pulse
//   rd_idx, rd_data : debug membrane read, one cycle latency
module lif_array
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = 16,
    parameter int WIDTH      = 16,
    parameter int THRESH     = 32,
    parameter int RESET_VAL  = 0,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    leak_en,
    output logic [IDX_W-1:0]        cur_idx,
    input  logic signed [WIDTH-1:0] cur_in,
    output logic                    spk_valid,
    output logic [IDX_W-1:0]        spk_idx,
    output logic                    spk,
    output logic                    busy,
    output logic                    done,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [WIDTH-1:0] rd_data
);

    localparam int                      RF_W     = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic signed [WIDTH-1:0] RST_MEM  = WIDTH'(RESET_VAL);

    state_t                  state_r;
    state_t                  state_s;
    logic                    accept_s;
    logic                    last_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    leak_l_r;
    logic signed [WIDTH-1:0] mem_r    [N_NEURONS];
    logic [RF_W-1:0]         refrac_r [N_NEURONS];

    logic signed [WIDTH-1:0] core_mem_s;
    logic [RF_W-1:0]         core_refrac_s;
    logic                    core_fire_s;

    logic                    spk_valid_r;
    logic [IDX_W-1:0]        spk_idx_r;
    logic                    spk_r;
    logic                    busy_r;
    logic                    done_r;
    logic signed [WIDTH-1:0] rd_data_r;

    lif_core #(
        .WIDTH      (WIDTH),
        .THRESH     (THRESH),
        .RESET_VAL  (RESET_VAL),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .RF_W       (RF_W)
    ) u_core (
        .mem         (mem_r[idx_r]),
        .cur         (cur_in),
        .refrac      (refrac_r[idx_r]),
        .leak_en     (leak_l_r),
        .next_mem    (core_mem_s),
        .next_refrac (core_refrac_s),
        .fire        (core_fire_s)
    );

    // Next-state logic; start wins over clear, both only seen in IDLE.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = RUN;
                    accept_s = 1'b1;
                end else if (clear) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = IDLE;
                    last_s  = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            CLEAR:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Sweep index (held at 0 outside RUN) and leak enable latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= '0;
            leak_l_r <= 1'b0;
        end else begin
            if (state_r == RUN) begin
                idx_r <= last_s ? '0 : (idx_r + IDX_W'(1'b1));
            end
            if (accept_s) begin
                leak_l_r <= leak_en;
            end
        end
    end

    // Per-neuron membrane and refractory storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_r[i]    <= RST_MEM;
                refrac_r[i] <= '0;
            end
        end else if (state_r == CLEAR) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_r[i]    <= RST_MEM;
                refrac_r[i] <= '0;
            end
        end else if (state_r == RUN) begin
            mem_r[idx_r]    <= core_mem_s;
            refrac_r[idx_r] <= core_refrac_s;
        end
    end

    // Spike-stream, status and debug-read output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_valid_r <= 1'b0;
            spk_idx_r   <= '0;
            spk_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rd_data_r   <= RST_MEM;
        end else begin
            spk_valid_r <= (state_r == RUN);
            spk_idx_r   <= (state_r == RUN) ? idx_r : '0;
            spk_r       <= (state_r == RUN) && core_fire_s;
            // busy covers the extra cycle in which the last entry is shown.
            busy_r      <= (state_s == RUN) || last_s;
            done_r      <= last_s;
            // Array read sees the value before any same-edge write.
            rd_data_r   <= (int'(rd_idx) < N_NEURONS) ? mem_r[rd_idx] : RST_MEM;
        end
    end

    assign cur_idx   = idx_r;
    assign spk_valid = spk_valid_r;
    assign spk_idx   = spk_idx_r;
    assign spk       = spk_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array (N=4, WIDTH=16, THRESH=32, LEAK_SHIFT=1,
// REFRAC=2). A vector table drives whole timesteps or clears and checks the
// spike pattern and every membrane afterwards; hand-written sequences cover
// ignored start/clear during RUN, done timing and reset mid-RUN.
module tb_lif_array;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    typedef struct packed {
        logic             op;   // 1: clear, 0: run one timestep
        logic             le;
        logic [3:0][15:0] cur;
        logic [3:0]       spk;
        logic [3:0][15:0] mem;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                clear;
    logic                leak_en;
    logic [IW-1:0]       cur_idx;
    logic signed [W-1:0] cur_in;
    logic                spk_valid;
    logic [IW-1:0]       spk_idx;
    logic                spk;
    logic                busy;
    logic                done;
    logic [IW-1:0]       rd_idx;
    logic signed [W-1:0] rd_data;

    int                  n_tests = 0;
    int                  n_fail  = 0;
    logic signed [W-1:0] cur_tab [N];
    vec_t                tab[$];

    always #5 clk = ~clk;

    lif_array #(
        .N_NEURONS (N),
        .WIDTH     (W),
        .THRESH    (32),
        .RESET_VAL (0),
        .LEAK_SHIFT(1),
        .REFRAC    (2),
        .IDX_W     (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .leak_en   (leak_en),
        .cur_idx   (cur_idx),
        .cur_in    (cur_in),
        .spk_valid (spk_valid),
        .spk_idx   (spk_idx),
        .spk       (spk),
        .busy      (busy),
        .done      (done),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic op, input logic le,
                                input int c0, input int c1, input int c2, input int c3,
                                input logic [3:0] sp,
                                input int m0, input int m1, input int m2, input int m3);
        vec_t v;
        v.op  = op;
        v.le  = le;
        v.cur = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
        v.spk = sp;
        v.mem = {16'(m3), 16'(m2), 16'(m1), 16'(m0)};
        return v;
    endfunction

    // One timestep: returns the spike bits, checks stream framing and done.
    task automatic run_ts(input logic le, output logic [N-1:0] fired);
        fired = '0;
        @(negedge clk); start = 1'b1; leak_en = le;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin
                cur_in = cur_tab[k];
                check("cur_idx", cur_idx, k);
            end else begin
                cur_in = '0;
            end
            check("busy_run", busy, 1);
            check("done_timing", done, (k == N) ? 1 : 0);
            if (k > 0) begin
                check("spk_valid", spk_valid, 1);
                check("spk_idx", spk_idx, k - 1);
                fired[k-1] = spk;
            end
            if (k < N) @(negedge clk);
        end
    endtask

    task automatic do_clear();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("busy_clear", busy, 0);
    endtask

    task automatic check_mems(input logic [3:0][15:0] m);
        for (int k = 0; k < N; k++) begin
            @(negedge clk); rd_idx = IW'(k);
            @(negedge clk); check($sformatf("mem%0d", k), rd_data, $signed(m[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] fired;
        int           cyc;
        int           got;
        int           seen;

        rst_n = 1'b0; start = 1'b0; clear = 1'b0; leak_en = 1'b0;
        cur_in = '0; rd_idx = '0;
        for (int k = 0; k < N; k++) cur_tab[k] = '0;

        // Integrate without leak: fire together on the 4th step.
        tab.push_back(mk(0, 0, 10, 10, 10, 10, 4'b0000, 10, 10, 10, 10));
        tab.push_back(mk(0, 0, 10, 10, 10, 10, 4'b0000, 20, 20, 20, 20));
        tab.push_back(mk(0, 0, 10, 10, 10, 10, 4'b0000, 30, 30, 30, 30));
        tab.push_back(mk(0, 0, 10, 10, 10, 10, 4'b1111, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Leak: positive settles at 10, negative decays toward 0 without flipping.
        tab.push_back(mk(0, 1, 10, 10, 10, -7, 4'b0000, 5, 5, 5, -3));
        tab.push_back(mk(0, 1, 10, 10, 10, -7, 4'b0000, 8, 8, 8, -5));
        tab.push_back(mk(0, 1, 10, 10, 10, -7, 4'b0000, 9, 9, 9, -6));
        tab.push_back(mk(0, 1, 10, 10, 10, -7, 4'b0000, 10, 10, 10, -6));
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Refractory: neuron 1 fires in steps 1, 4, 7 only.
        for (int t = 1; t <= 7; t++) begin
            tab.push_back(mk(0, 0, 0, 40, 0, 0,
                             (t == 1 || t == 4 || t == 7) ? 4'b0010 : 4'b0000, 0, 0, 0, 0));
        end
        tab.push_back(mk(1, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Threshold equality and saturation at both rails.
        tab.push_back(mk(0, 0, -30000, 32, 31, 31, 4'b0010, -30000, 0, 31, 31));
        tab.push_back(mk(0, 0, -30000, 0, 32767, 0, 4'b0100, -32768, 0, 0, 31));

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_spk", spk, 0);
        check("rst_spk_idx", spk_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cur_idx", cur_idx, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;

        foreach (tab[i]) begin
            if (tab[i].op) begin
                do_clear();
            end else begin
                for (int k = 0; k < N; k++) cur_tab[k] = $signed(tab[i].cur[k]);
                run_ts(tab[i].le, fired);
                check($sformatf("spikes_v%0d", i), fired, tab[i].spk);
            end
            check_mems(tab[i].mem);
        end

        // start and clear pulsed mid-RUN are ignored and not queued.
        for (int k = 0; k < N; k++) cur_tab[k] = '0;
        cur_in = '0; leak_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; got = 0;
        while (cyc <= 3 * N && got == 0) begin
            if (cyc == 2) begin start = 1'b1; clear = 1'b1; end
            else begin start = 1'b0; clear = 1'b0; end
            if (done) got = cyc;
            if (got == 0) begin @(negedge clk); cyc++; end
        end
        start = 1'b0; clear = 1'b0;
        check("done_cycle", got, N + 1);
        @(negedge clk);
        check("no_requeue_busy", busy, 0);
        check("no_requeue_valid", spk_valid, 0);
        check("no_requeue_done", done, 0);
        check_mems({16'sd31, 16'sd0, 16'sd0, -16'sd32768});
        do_clear();
        check_mems('0);

        // Reset while neuron 2 is being evaluated.
        for (int k = 0; k < N; k++) cur_tab[k] = 16'sd7;
        @(negedge clk); start = 1'b1; rd_idx = '0;
        @(negedge clk); start = 1'b0; cur_in = cur_tab[0];
        @(negedge clk); cur_in = cur_tab[1];
        check("rd_prewrite", rd_data, 0);
        @(negedge clk); cur_in = cur_tab[2];
        check("rd_postwrite", rd_data, 7);
        rst_n = 1'b0;
        #1;
        check("arst_spk_valid", spk_valid, 0);
        check("arst_spk_idx", spk_idx, 0);
        check("arst_busy", busy, 0);
        check("arst_cur_idx", cur_idx, 0);
        check("arst_rd_data", rd_data, 0);
        @(negedge clk); rst_n = 1'b1; cur_in = '0;
        seen = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("arst_no_done", seen, 0);
        check_mems('0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
